// File: rtl/dll_dcntl_ctrl.sv
// rtl/dll_dcntl_ctrl.sv - DLL delay-code controller: vote filter, clamped code stepping, lock detection.
module dll_dcntl_ctrl #(
  parameter logic [8:0] INIT_CODE  = 9'd256,
  parameter int         STEP       = 1,
  parameter int         FILTER_LEN = 4,
  parameter int         LOCK_CNT   = 8,
  parameter int         UNLOCK_RUN = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PD_UP,
  input  logic       PD_DN,
  input  logic       HOLD,
  input  logic       UPD,
  output logic [8:0] DCNTL,
  output logic       LOCK
);

  localparam logic [0:0] ACQUIRE = 1'b0;
  localparam logic [0:0] LOCKED  = 1'b1;

  localparam logic [3:0] FL4 = 4'(FILTER_LEN);
  localparam logic [3:0] LC4 = 4'(LOCK_CNT);
  localparam logic [3:0] UR4 = 4'(UNLOCK_RUN);
  localparam logic [8:0] ST9 = 9'(STEP);

  logic [8:0] code;
  logic [3:0] run;
  logic       rdir;
  logic       last_step_dir;
  logic [3:0] rev;
  logic [3:0] srun;
  logic [0:0] state;

  logic       vote;
  logic       vdir;
  logic [3:0] run_inc;
  logic       step;
  logic [9:0] sum_up;
  logic [8:0] code_up;
  logic [8:0] code_dn;
  logic [3:0] rev_n;
  logic [3:0] srun_n;

  // Direction encoding: 1 = up (increase delay), 0 = down.
  always_comb begin
    vote    = PD_UP ^ PD_DN;
    vdir    = PD_UP;
    run_inc = (vdir == rdir) ? run + 4'd1 : 4'd1;
    step    = !HOLD && vote && (run_inc == FL4);

    sum_up  = {1'b0, code} + {1'b0, ST9};
    code_up = (sum_up > 10'd511) ? 9'd511 : sum_up[8:0];
    code_dn = (code < ST9) ? 9'd0 : code - ST9;

    if (vdir != last_step_dir) begin
      rev_n  = (rev == 4'd15) ? 4'd15 : rev + 4'd1;
      srun_n = 4'd1;
    end else begin
      rev_n  = rev;
      srun_n = (srun == 4'd15) ? 4'd15 : srun + 4'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      code          <= INIT_CODE;
      DCNTL         <= INIT_CODE;
      run           <= 4'd0;
      rdir          <= 1'b1;
      last_step_dir <= 1'b1;
      rev           <= 4'd0;
      srun          <= 4'd0;
      state         <= ACQUIRE;
    end else begin
      // DCNTL takes the pre-edge code, so it trails code by one UPD edge.
      if (UPD) DCNTL <= code;

      if (HOLD) begin
        run <= 4'd0;
      end else if (vote) begin
        rdir <= vdir;
        run  <= step ? 4'd0 : run_inc;
      end

      if (step) begin
        code          <= vdir ? code_up : code_dn;
        last_step_dir <= vdir;
        if (state == ACQUIRE && rev_n == LC4) begin
          state <= LOCKED;
          rev   <= 4'd0;
          srun  <= 4'd0;
        end else if (state == LOCKED && srun_n == UR4) begin
          state <= ACQUIRE;
          rev   <= 4'd0;
          srun  <= 4'd0;
        end else begin
          rev  <= rev_n;
          srun <= srun_n;
        end
      end
    end
  end

  assign LOCK = (state == LOCKED);

endmodule

// File: tb/tb_dll_dcntl_ctrl.sv
// tb/tb_dll_dcntl_ctrl.sv - scoreboard bench for dll_dcntl_ctrl with three INIT_CODE variants.
module tb_dll_dcntl_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       PD_UP = 1'b0, PD_DN = 1'b0, HOLD = 1'b0, UPD = 1'b1;
  logic [8:0] dc [3];
  logic       lk [3];

  always #5 CLK = ~CLK;

  dll_dcntl_ctrl u_dut (
    .CLK(CLK), .RST(RST), .PD_UP(PD_UP), .PD_DN(PD_DN), .HOLD(HOLD), .UPD(UPD),
    .DCNTL(dc[0]), .LOCK(lk[0]));
  dll_dcntl_ctrl #(.INIT_CODE(9'd510)) u_dut_hi (
    .CLK(CLK), .RST(RST), .PD_UP(PD_UP), .PD_DN(PD_DN), .HOLD(HOLD), .UPD(UPD),
    .DCNTL(dc[1]), .LOCK(lk[1]));
  dll_dcntl_ctrl #(.INIT_CODE(9'd0)) u_dut_lo (
    .CLK(CLK), .RST(RST), .PD_UP(PD_UP), .PD_DN(PD_DN), .HOLD(HOLD), .UPD(UPD),
    .DCNTL(dc[2]), .LOCK(lk[2]));

  typedef struct {
    int inst;
    int dcntl;
    bit lock;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference model: filter is the list of pending same-direction votes;
  // rev/srun/lock do not depend on the code, so only code/dcntl are per instance.
  int init_c [3] = '{256, 510, 0};
  int m_code [3];
  int m_dcntl[3];
  bit vq[$];
  int m_rev, m_srun;
  bit m_last, m_lock;

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_code[i]  = init_c[i];
      m_dcntl[i] = init_c[i];
    end
    vq.delete();
    m_rev = 0; m_srun = 0; m_last = 1'b1; m_lock = 1'b0;
  endtask

  task automatic model_step(input bit up, input bit dn, input bit hold, input bit upd);
    bit dir;
    bit do_step;
    dir = up;
    do_step = 1'b0;
    if (upd) for (int i = 0; i < 3; i++) m_dcntl[i] = m_code[i];
    if (hold) vq.delete();
    else if (up != dn) begin
      if (vq.size() > 0 && vq[0] != dir) vq.delete();
      vq.push_back(dir);
      if (vq.size() == 4) begin
        do_step = 1'b1;
        vq.delete();
      end
    end
    if (do_step) begin
      for (int i = 0; i < 3; i++)
        m_code[i] = dir ? ((m_code[i] + 1 > 511) ? 511 : m_code[i] + 1)
                        : ((m_code[i] - 1 < 0) ? 0 : m_code[i] - 1);
      if (dir != m_last) begin
        m_rev  = (m_rev < 15) ? m_rev + 1 : 15;
        m_srun = 1;
      end else begin
        m_srun = (m_srun < 15) ? m_srun + 1 : 15;
      end
      m_last = dir;
      if (!m_lock && m_rev == 8) begin
        m_lock = 1'b1; m_rev = 0; m_srun = 0;
      end else if (m_lock && m_srun == 4) begin
        m_lock = 1'b0; m_rev = 0; m_srun = 0;
      end
    end
  endtask

  task automatic cycle(input bit up, input bit dn, input bit hold, input bit upd);
    exp_t e;
    PD_UP = up; PD_DN = dn; HOLD = hold; UPD = upd;
    model_step(up, dn, hold, upd);
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      e.inst = i; e.dcntl = m_dcntl[i]; e.lock = m_lock;
      sb.push_back(e);
    end
  endtask

  // Reset is asserted between edges and checked before any clock edge occurs.
  task automatic do_reset();
    @(negedge CLK);
    #1;
    RST = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      check("reset_dcntl", int'(dc[i]), init_c[i]);
      check("reset_lock", int'(lk[i]), 0);
    end
    #1;
    RST = 1'b0;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      check($sformatf("dcntl[%0d]", e.inst), int'(dc[e.inst]), e.dcntl);
      check($sformatf("lock[%0d]", e.inst), int'(lk[e.inst]), int'(e.lock));
    end
  end

  initial begin
    bit dir;
    int len;
    bit hold_r, upd_r;

    do_reset();
    for (int k = 0; k < 4; k++) cycle(1, 0, 0, 1);
    check("filter_code_257", int'(dc[0]), 256);
    cycle(0, 0, 0, 1);
    check("filter_dcntl_257", int'(dc[0]), 257);

    do_reset();
    cycle(1, 0, 0, 1); cycle(1, 0, 0, 1); cycle(0, 1, 0, 1);
    cycle(1, 0, 0, 1); cycle(1, 0, 0, 1); cycle(0, 0, 0, 1);
    check("broken_run_no_step", int'(dc[0]), 256);

    do_reset();
    for (int k = 0; k < 12; k++) cycle(1, 0, 0, 1);
    cycle(1, 1, 0, 1);
    check("sat_high", int'(dc[1]), 511);

    do_reset();
    for (int k = 0; k < 12; k++) cycle(0, 1, 0, 1);
    cycle(0, 0, 0, 1);
    check("sat_low", int'(dc[2]), 0);

    do_reset();
    for (int s = 0; s < 9; s++) begin
      for (int k = 0; k < 4; k++) cycle(s % 2 == 0, s % 2 != 0, 0, 1);
      if (s == 7) check("lock_before_9th", int'(lk[0]), 0);
    end
    check("lock_on_9th", int'(lk[0]), 1);
    for (int k = 0; k < 12; k++) cycle(1, 0, 0, 1);
    check("lock_held_3rd", int'(lk[0]), 1);
    for (int k = 0; k < 4; k++) cycle(1, 0, 0, 1);
    check("unlock_on_4th", int'(lk[0]), 0);

    do_reset();
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 1);
    for (int k = 0; k < 10; k++) cycle(1, 0, 1, 1);
    cycle(1, 0, 0, 1);
    check("hold_freeze", int'(dc[0]), 256);

    do_reset();
    for (int k = 0; k < 8; k++) cycle(1, 0, 0, 0);
    check("upd_low_hold", int'(dc[0]), 256);
    cycle(0, 0, 0, 1);
    check("upd_transfer", int'(dc[0]), 258);

    do_reset();
    for (int k = 0; k < 176; k++) cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check("midrun_code_300", int'(dc[0]), 300);
    do_reset();

    dir = 1'b1; len = 0; hold_r = 1'b0; upd_r = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (len == 0) begin
        dir    = $urandom_range(1, 0) == 1;
        len    = $urandom_range(9, 1);
        hold_r = $urandom_range(15, 0) == 0;
        upd_r  = $urandom_range(7, 0) != 0;
      end
      len--;
      if ($urandom_range(9, 0) == 0) cycle($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, hold_r, upd_r);
      else cycle(dir, !dir, hold_r, upd_r);
      if ($urandom_range(599, 0) == 0) do_reset();
    end

    @(posedge CLK);
    @(posedge CLK);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
